// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants and state encoding for the hex 7-segment serializer
package seg_pkg;

   // Active-low segment bytes {dp_n,g,f,e,d,c,b,a}, indexed by hex value
   localparam logic [7:0] SEG_HEX [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
   };

   localparam logic [7:0]  SEG_BLANK  = 8'hFF;
   localparam int unsigned SEG_DP_BIT = 7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_LATCH = 2'd2
   } state_e;

endpackage

// File: rtl/hex_to_seg.sv
// rtl/hex_to_seg.sv - one hex nibble plus dp/blank flags to an active-low segment byte
module hex_to_seg
   import seg_pkg::*;
(
   input  logic [3:0] nibble_i,
   input  logic       dp_i,
   input  logic       blank_i,
   output logic [7:0] seg_o
);

   // Table lookup, then the decimal point, then blanking which overrides both
   always_comb begin
      seg_o = SEG_HEX[nibble_i];
      if (dp_i) begin
         seg_o[SEG_DP_BIT] = 1'b0;
      end
      if (blank_i) begin
         seg_o = SEG_BLANK;
      end
   end

endmodule

// File: rtl/hex_seg_p2s.sv
// rtl/hex_seg_p2s.sv - decodes NDIG hex digits and shifts the segment frame out serially
module hex_seg_p2s
   import seg_pkg::*;
#(
   parameter int NDIG = 4,
   parameter int DIV  = 2
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [4*NDIG-1:0] num,
   input  logic [NDIG-1:0]   dp,
   input  logic [NDIG-1:0]   blank,
   output logic              busy,
   output logic              done,
   output logic              seg_clk,
   output logic              seg_dat,
   output logic              seg_pen
);

   localparam int FW = 8 * NDIG;
   localparam int CW = $clog2(2 * DIV);
   localparam int BW = $clog2(FW);

   // Divider phase at which seg_clk rises, and the final phase of a bit
   localparam logic [CW-1:0] CNT_RISE = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(2 * DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(FW - 1);

   logic [FW-1:0] frame_dec;
   logic [FW-1:0] frame_q, frame_d;
   logic [CW-1:0] div_q, div_d;
   logic [BW-1:0] bit_q, bit_d;
   state_e        state_q;
   logic          busy_q, done_q, clk_q, pen_q;

   // Digit NDIG-1 lands in the top byte so it leaves the chain first
   for (genvar g = 0; g < NDIG; g++) begin : g_dec
      hex_to_seg u_dec (
         .nibble_i (num[4*g +: 4]),
         .dp_i     (dp[g]),
         .blank_i  (blank[g]),
         .seg_o    (frame_dec[8*g +: 8])
      );
   end

   // Next values for the counters and the left-shifting frame
   always_comb begin
      div_d   = div_q + 1'b1;
      bit_d   = bit_q + 1'b1;
      frame_d = {frame_q[FW-2:0], 1'b0};
   end

   // Serializer FSM; the frame is shifted once per bit including the last, so it ends all-zero and seg_dat idles low
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         clk_q   <= 1'b0;
         pen_q   <= 1'b0;
         div_q   <= '0;
         bit_q   <= '0;
         frame_q <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  frame_q <= frame_dec;
                  clk_q   <= 1'b0;
                  div_q   <= '0;
                  bit_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               div_q <= div_d;
               if (div_q == CNT_RISE) begin
                  clk_q <= 1'b1;
               end
               if (div_q == CNT_LAST) begin
                  div_q   <= '0;
                  clk_q   <= 1'b0;
                  frame_q <= frame_d;
                  if (bit_q == BIT_LAST) begin
                     pen_q   <= 1'b1;
                     state_q <= ST_LATCH;
                  end else begin
                     bit_q <= bit_d;
                  end
               end
            end
            ST_LATCH: begin
               div_q <= div_d;
               if (div_q == CNT_LAST) begin
                  div_q   <= '0;
                  pen_q   <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign seg_clk = clk_q;
   assign seg_dat = frame_q[FW-1];
   assign seg_pen = pen_q;

endmodule

// File: tb/tb_hex_seg_p2s.sv
// tb/tb_hex_seg_p2s.sv - self-checking bench for hex_seg_p2s
module tb_hex_seg_p2s;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        start_a;
   logic [15:0] num_a;
   logic [3:0]  dp_a, blank_a;
   logic        busy_a, done_a, sclk_a, sdat_a, pen_a;

   logic        start_b;
   logic [3:0]  num_b;
   logic [0:0]  dp_b, blank_b;
   logic        busy_b, done_b, sclk_b, sdat_b, pen_b;

   hex_seg_p2s #(.NDIG(4), .DIV(2)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .num(num_a), .dp(dp_a), .blank(blank_a),
      .busy(busy_a), .done(done_a), .seg_clk(sclk_a), .seg_dat(sdat_a), .seg_pen(pen_a)
   );

   hex_seg_p2s #(.NDIG(1), .DIV(1)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .num(num_b), .dp(dp_b), .blank(blank_b),
      .busy(busy_b), .done(done_b), .seg_clk(sclk_b), .seg_dat(sdat_b), .seg_pen(pen_b)
   );

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   always @(posedge clk) cyc++;

   // Observers for instance A
   logic bq_a[$];
   int   done_a_cyc[$];
   int   pen_a_cnt = 0;
   int   idle_a_cnt = 0;
   logic sclk_a_prev = 1'b0;

   always @(negedge clk) begin
      if (sclk_a && !sclk_a_prev) bq_a.push_back(sdat_a);
      sclk_a_prev = sclk_a;
      if (pen_a) pen_a_cnt++;
      if (done_a) done_a_cyc.push_back(cyc);
      if (!busy_a && !done_a) idle_a_cnt++;
   end

   // Observers for instance B
   logic bq_b[$];
   int   done_b_cyc[$];
   int   pen_b_cnt = 0;
   int   run_b = 0;
   int   hi_min_b = 1000;
   int   hi_max_b = 0;
   logic sclk_b_prev = 1'b0;

   always @(negedge clk) begin
      if (sclk_b && !sclk_b_prev) bq_b.push_back(sdat_b);
      sclk_b_prev = sclk_b;
      if (sclk_b) begin
         run_b++;
      end else if (run_b > 0) begin
         if (run_b < hi_min_b) hi_min_b = run_b;
         if (run_b > hi_max_b) hi_max_b = run_b;
         run_b = 0;
      end
      if (pen_b) pen_b_cnt++;
      if (done_b) done_b_cyc.push_back(cyc);
   end

   // Reference: lit segments in positive gfedcba form, inverted to active-low
   function automatic logic [7:0] seg_ref(input logic [3:0] h, input logic d, input logic b);
      logic [6:0] lit;
      case (h)
         4'h0: lit = 7'h3F;  4'h1: lit = 7'h06;  4'h2: lit = 7'h5B;  4'h3: lit = 7'h4F;
         4'h4: lit = 7'h66;  4'h5: lit = 7'h6D;  4'h6: lit = 7'h7D;  4'h7: lit = 7'h07;
         4'h8: lit = 7'h7F;  4'h9: lit = 7'h6F;  4'hA: lit = 7'h77;  4'hB: lit = 7'h7C;
         4'hC: lit = 7'h39;  4'hD: lit = 7'h5E;  4'hE: lit = 7'h79;  default: lit = 7'h71;
      endcase
      if (b) return 8'hFF;
      return {~d, ~lit};
   endfunction

   function automatic logic [63:0] frame_ref(input logic [31:0] n, input logic [7:0] d,
                                             input logic [7:0] b, input int ndig);
      logic [63:0] f = '0;
      for (int i = ndig - 1; i >= 0; i--) f = {f[55:0], seg_ref(n[4*i +: 4], d[i], b[i])};
      return f;
   endfunction

   function automatic logic [63:0] qbits_a(input int off, input int n);
      logic [63:0] r = '0;
      for (int i = 0; i < n; i++) r = {r[62:0], bq_a[off + i]};
      return r;
   endfunction

   function automatic logic [63:0] qbits_b(input int n);
      logic [63:0] r = '0;
      for (int i = 0; i < n; i++) r = {r[62:0], bq_b[i]};
      return r;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clr_a();
      bq_a.delete();
      done_a_cyc.delete();
      pen_a_cnt  = 0;
      idle_a_cnt = 0;
   endtask

   task automatic wait_done_a(input int n, input int bound, input string tag);
      int k = 0;
      while (done_a_cyc.size() < n && k < bound) begin
         tick();
         k++;
      end
      check({tag, "_done_seen"}, 64'(done_a_cyc.size()), 64'(n));
   endtask

   // One start pulse on instance A, then bits, latch width, latency and single done
   task automatic frame_a(input logic [15:0] n, input logic [3:0] d, input logic [3:0] b,
                          input string tag);
      logic [63:0] exp;
      int s;
      exp = frame_ref({16'h0, n}, {4'h0, d}, {4'h0, b}, 4);
      num_a = n; dp_a = d; blank_a = b;
      clr_a();
      start_a = 1'b1;
      s = cyc + 1;
      tick();
      start_a = 1'b0;
      wait_done_a(1, 400, tag);
      tick();
      tick();
      check({tag, "_nbits"}, 64'(bq_a.size()), 64'd32);
      check({tag, "_bits"}, qbits_a(0, 32), exp);
      check({tag, "_pen"}, 64'(pen_a_cnt), 64'd4);
      check({tag, "_lat"}, 64'(done_a_cyc.size() > 0 ? done_a_cyc[0] - s + 1 : -1), 64'd133);
      check({tag, "_ndone"}, 64'(done_a_cyc.size()), 64'd1);
   endtask

   initial begin
      logic [15:0] n1, n2;
      logic [3:0]  d1, d2, b1, b2;
      logic [63:0] e1, e2;
      int s, nb, k;

      rst = 1'b1;
      start_a = 1'b0; num_a = '0; dp_a = '0; blank_a = '0;
      start_b = 1'b0; num_b = '0; dp_b = '0; blank_b = '0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("rst_busy", 64'(busy_a), 64'd0);
      check("rst_done", 64'(done_a), 64'd0);
      check("rst_sclk", 64'(sclk_a), 64'd0);
      check("rst_sdat", 64'(sdat_a), 64'd0);
      check("rst_pen", 64'(pen_a), 64'd0);

      // Directed frames with known bytes
      frame_a(16'h0123, 4'b0000, 4'b0000, "f0123");
      check("f0123_const", qbits_a(0, 32), 64'hC0F9A4B0);
      frame_a(16'hF8A0, 4'b0010, 4'b1000, "fdpblank");
      check("fdpblank_const", qbits_a(0, 32), 64'hFF8008C0);

      // Randomized frames
      for (int i = 0; i < 6; i++) begin
         frame_a(16'($urandom), 4'($urandom), 4'($urandom) & 4'($urandom), $sformatf("rnd%0d", i));
      end

      // Start re-pulsed and inputs changed mid-frame: frame unchanged, one done
      n1 = 16'($urandom); d1 = 4'($urandom); b1 = 4'h0;
      e1 = frame_ref({16'h0, n1}, {4'h0, d1}, {4'h0, b1}, 4);
      num_a = n1; dp_a = d1; blank_a = b1;
      clr_a();
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      repeat (40) tick();
      num_a = ~n1; dp_a = ~d1; blank_a = 4'b0101;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      wait_done_a(1, 400, "hs");
      repeat (150) tick();
      check("hs_bits", qbits_a(0, 32), e1);
      check("hs_ndone", 64'(done_a_cyc.size()), 64'd1);
      check("hs_idle_busy", 64'(busy_a), 64'd0);

      // Start held high: back-to-back frames, second reflects inputs at first done
      n1 = 16'($urandom); d1 = 4'($urandom); b1 = 4'($urandom) & 4'($urandom);
      n2 = 16'($urandom); d2 = 4'($urandom); b2 = 4'($urandom) & 4'($urandom);
      e1 = frame_ref({16'h0, n1}, {4'h0, d1}, {4'h0, b1}, 4);
      e2 = frame_ref({16'h0, n2}, {4'h0, d2}, {4'h0, b2}, 4);
      num_a = n1; dp_a = d1; blank_a = b1;
      clr_a();
      start_a = 1'b1;
      s = cyc + 1;
      repeat (60) tick();
      num_a = n2; dp_a = d2; blank_a = b2;
      repeat (240) tick();
      check("b2b_ndone", 64'(done_a_cyc.size()), 64'd2);
      check("b2b_lat1", 64'(done_a_cyc.size() > 0 ? done_a_cyc[0] - s + 1 : -1), 64'd133);
      check("b2b_lat2", 64'(done_a_cyc.size() > 1 ? done_a_cyc[1] - s + 1 : -1), 64'd266);
      check("b2b_idle", 64'(idle_a_cnt), 64'd0);
      check("b2b_bits1", qbits_a(0, 32), e1);
      check("b2b_bits2", qbits_a(32, 32), e2);
      start_a = 1'b0;
      wait_done_a(3, 400, "b2b_tail");
      tick();

      // Reset in the middle of bit 10 aborts with no latch pulse
      clr_a();
      num_a = 16'($urandom); dp_a = '0; blank_a = '0;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      k = 0;
      while (bq_a.size() < 11 && k < 200) begin
         tick();
         k++;
      end
      check("mid_reached_bit10", 64'(bq_a.size()), 64'd11);
      rst = 1'b1;
      tick();
      check("mid_rst_busy", 64'(busy_a), 64'd0);
      check("mid_rst_sclk", 64'(sclk_a), 64'd0);
      check("mid_rst_pen", 64'(pen_a), 64'd0);
      check("mid_rst_done", 64'(done_a), 64'd0);
      rst = 1'b0;
      nb = bq_a.size();
      repeat (80) tick();
      check("mid_no_edges", 64'(bq_a.size()), 64'(nb));
      check("mid_no_pen", 64'(pen_a_cnt), 64'd0);
      check("mid_no_done", 64'(done_a_cyc.size()), 64'd0);

      // Single digit, DIV=1 instance
      for (int i = 0; i < 3; i++) begin
         num_b = (i == 0) ? 4'hE : 4'($urandom);
         dp_b = (i == 0) ? 1'b0 : 1'($urandom);
         blank_b = (i == 2) ? 1'($urandom) : 1'b0;
         e1 = frame_ref({28'h0, num_b}, {7'h0, dp_b}, {7'h0, blank_b}, 1);
         bq_b.delete(); done_b_cyc.delete();
         pen_b_cnt = 0; hi_min_b = 1000; hi_max_b = 0;
         start_b = 1'b1;
         s = cyc + 1;
         tick();
         start_b = 1'b0;
         k = 0;
         while (done_b_cyc.size() < 1 && k < 100) begin
            tick();
            k++;
         end
         tick();
         check($sformatf("b%0d_done_seen", i), 64'(done_b_cyc.size()), 64'd1);
         check($sformatf("b%0d_nbits", i), 64'(bq_b.size()), 64'd8);
         check($sformatf("b%0d_bits", i), qbits_b(8), e1);
         check($sformatf("b%0d_lat", i), 64'(done_b_cyc.size() > 0 ? done_b_cyc[0] - s + 1 : -1), 64'd19);
         check($sformatf("b%0d_hi_min", i), 64'(hi_min_b), 64'd1);
         check($sformatf("b%0d_hi_max", i), 64'(hi_max_b), 64'd1);
         check($sformatf("b%0d_pen", i), 64'(pen_b_cnt), 64'd2);
         check($sformatf("b%0d_busy", i), 64'(busy_b), 64'd0);
      end
      check("b_E_const", qbits_b(8) & 64'h0, 64'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/hex_seg_p2s.md
Name: hex_seg_p2s

Overview:
- Downstream of the button-driven 4-bit counter. Takes NDIG hex nibbles (counter values) plus per-digit decimal-point and blank flags, and decodes each to a 7-segment byte.
- Shifts the resulting 8*NDIG-bit frame out serially to the board's external shift-register chain, then pulses a latch strobe.
- Single clock domain, start/busy/done handshake; the top level asserts start whenever it wants the display refreshed.

Parameters:
- NDIG, 4, number of digits in the frame (1..8).
- DIV, 2, system clocks per seg_clk half-period (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request to send a frame; sampled only in IDLE
- num  in  4*NDIG  hex digits; num[3:0] = digit 0 (rightmost)
- dp  in  NDIG  1 = light decimal point of digit i
- blank  in  NDIG  1 = digit i fully off (overrides num and dp)
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at frame end
- seg_clk  out  1  serial clock to shift-register chain, idles low
- seg_dat  out  1  serial data, MSB first
- seg_pen  out  1  latch/output-enable strobe, active high

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state=IDLE; busy=0, done=0, seg_clk=0, seg_dat=0, seg_pen=0; divider counter and bit counter cleared. Reset mid-frame aborts immediately; no partial latch pulse.
- Segment byte per digit, active low: {dp_n,g,f,e,d,c,b,a}.
  - Hex decode: 0=0xC0, 1=0xF9, 2=0xA4, 3=0xB0, 4=0x99, 5=0x92, 6=0x82, 7=0xF8, 8=0x80, 9=0x90, A=0x88, b=0x83, C=0xC6, d=0xA1, E=0x86, F=0x8E.
  - dp[i]=1 clears bit 7.
  - blank[i]=1 forces 0xFF.
- Frame order: digit NDIG-1 first, bit 7 of each byte first. Frame width = 8*NDIG.
- States: IDLE -> SHIFT -> LATCH -> IDLE.
- IDLE:
  - busy=0.
  - start=1 snapshots num/dp/blank into the decoded frame register (later input changes are ignored). Next cycle: state=SHIFT, busy=1, seg_dat = frame MSB, seg_clk=0.
- SHIFT:
  - Each bit occupies 2*DIV clocks: DIV clocks with seg_clk=0, then DIV clocks with seg_clk=1. Data changes only on the seg_clk falling transition, so it is stable DIV clocks before each rising edge.
  - After the last bit's high phase: seg_clk=0, seg_dat=0, state=LATCH.
- LATCH:
  - seg_pen=1 for 2*DIV clocks.
  - Then state=IDLE, busy=0, done=1 for exactly one cycle.
- Latency: done asserts 1 + 2*DIV*(8*NDIG+1) clocks after the start edge. Defaults: 133.
- start while busy=1 is ignored, not queued.
- start=1 in the same cycle done=1 (state already IDLE) is accepted normally, giving back-to-back frames.
- start held high continuously gives continuous refresh with exactly one done per frame.
- Divider and bit counters use $clog2 widths; no wrap beyond frame length.

Decomposition:
- Shared package (seg_pkg): 16-entry hex-to-segment constant table, SEG_BLANK=8'hFF, DP bit index constant, state encoding for IDLE/SHIFT/LATCH.
- One natural combinational sub-module: hex_to_seg (4-bit nibble, dp, blank -> 8-bit active-low byte), instantiated NDIG times by generate.
- Serializer FSM, divider and shift register stay in hex_seg_p2s.

Test Plan:
- Reset: assert rst mid-SHIFT (bit 10) -> next cycle busy=0, seg_clk=0, seg_pen=0, done=0; no further seg_clk edges until a new start.
- Single frame: num=16'h0123, dp=0, blank=0, start 1 cycle -> 32 rising seg_clk edges sample C0,F9,A4,B0 (digit 3 first, MSB first); seg_pen high 4 clocks; done pulses at start+133.
- DP and blank: num=16'hF8A0, dp=4'b0010, blank=4'b1000 -> bytes FF,80,08,C0 (digit 1 byte 0x88 with bit 7 cleared = 0x08).
- Handshake: start re-pulsed while busy and num changed mid-frame -> frame unchanged; exactly one done.
- Back-to-back: start held high 300 clocks -> done pulses at 133 and 266; busy low only on done cycles; second frame reflects inputs sampled at the first done cycle.
- Parameters: DIV=1, NDIG=1, num=4'hE -> 8 bits 0x86, each seg_clk high 1 clock; done at start+19.
